instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Producer side of the decoder interface: fetches 32-bit instructions from instruction memory
//  over a valid/ready request + valid response bus, and presents them to instruction_decoder.
//  Decoder connection: instruction -> decoder.instruction; (instr_valid & ~stall) -> decoder.clk_enable.
//  Owns the PC; accepts redirects from branch/jump resolution. One fetch outstanding at a time.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset release
// PORTS
//  clk             in   1   single clock; all state updates on rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  mem_req_valid   out  1   fetch request valid
//  mem_req_ready   in   1   memory accepts request this cycle
//  mem_req_addr    out  32  fetch address, word aligned
//  mem_rsp_valid   in   1   read data valid (>=1 cycle after accept; memory never stalls response)
//  mem_rsp_data    in   32  fetched instruction word
//  redirect_valid  in   1   branch/jump taken; overrides sequential PC
//  redirect_pc     in   32  redirect target
//  stall           in   1   downstream cannot take instruction this cycle
//  instruction     out  32  registered instruction word to decoder
//  instr_pc        out  32  PC of presented instruction
//  instr_valid     out  1   instruction/instr_pc valid
//  fetch_fault     out  1   misaligned redirect target (MISALIGN_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  Reset: state=REQ, pc=RESET_PC, instr_valid=0, instruction=32'h0000_0013 (NOP),
//   instr_pc=0, mem_req_valid=0 during reset, fetch_fault=0.
//  States: REQ, WAIT, DELIVER, DRAIN, FAULT(macro only).
//  REQ: mem_req_valid=1, mem_req_addr=pc. On mem_req_ready -> WAIT. Addr held stable while !ready.
//  WAIT: on mem_rsp_valid: instruction<=mem_rsp_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4,
//   -> DELIVER. Latency: accept at N, rsp at M>N, instr_valid at M+1.
//  DELIVER: instr_valid=1, outputs frozen; if !stall -> REQ next cycle (instr_valid drops).
//   Throughput: max one instruction per 3 cycles with zero-wait memory.
//  pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
//  Redirect (highest priority, any state): instr_valid<=0 next cycle; pc<=redirect_pc.
//   REQ & !ready: latch target into pc_pending, keep old addr until accepted, then DRAIN.
//   REQ & ready same cycle: old request issued -> DRAIN.
//   WAIT & !rsp -> DRAIN; WAIT & rsp same cycle: response discarded -> REQ.
//   DELIVER -> REQ (delivered instr squashed even if stall=0).
//   DRAIN: discard next mem_rsp_valid, then REQ at redirect target; a further redirect in
//   DRAIN updates target only.
//  Without MISALIGN_TRAP_EN: redirect_pc[1:0] ignored (forced 2'b00).
//  Async reset mid-fetch: state returns to REQ at RESET_PC; in-flight response after release
//   is not expected (memory is reset by same rst_n).
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 -> FAULT (after draining any
//   outstanding response): no requests, instr_valid=0, fetch_fault=1 held until an aligned
//   redirect, which clears fault and -> REQ. Undefined: no FAULT state, fetch_fault tied 0.
// STRUCTURE
//  Package fetch_pkg: fetch_state_e enum, NOP_INSTR=32'h0000_0013, INSTR_W=32, PC_STEP=4.
//  No sub-module: FSM, PC register and output register stay in this module.
// TESTING
//  1 Reset release, ready=1, rsp 1 cycle later with 32'h00500093 -> req addr 0, then 4, 8;
//    instr_valid with instr_pc=0, instruction=32'h00500093, 3-cycle cadence.
//  2 stall=1 for 5 cycles during DELIVER -> instruction/instr_pc frozen, no mem_req_valid;
//    release -> next req at instr_pc+4.
//  3 redirect_pc=32'h100 while in WAIT -> first rsp discarded, next req addr 32'h100,
//    instr_valid never shows discarded word.
//  4 mem_req_ready low 4 cycles + redirect to 32'h200 mid-wait -> addr stable until accept,
//    response dropped, next req 32'h200.
//  5 RESET_PC=32'hFFFF_FFFC -> second fetch addr 32'h0000_0000.
//  6 MISALIGN_TRAP_EN: redirect 32'h102 -> fetch_fault=1, no reqs; redirect 32'h104 ->
//    fault clears, req 32'h104. Without macro: same stimulus -> req 32'h100, fault=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The FAULT state exists only when MISALIGN_TRAP_EN is defined.
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_DELIVER,
`ifdef MISALIGN_TRAP_EN
    ST_DRAIN,
    ST_FAULT
`else
    ST_DRAIN
`endif
  } fetch_state_e;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues one memory request at a time and presents
// the fetched word to the decoder. Optional misaligned-redirect trap: MISALIGN_TRAP_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [31:0]        mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               stall,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  output logic               fetch_fault
);

  fetch_state_e state, state_next, flush_state;
  logic [31:0]  pc, pc_next;
  logic [31:0]  pend_pc, pend_pc_next;
  logic         pend, pend_next;
  logic         load_instr, drop_valid;
  logic [31:0]  redirect_tgt;

`ifdef MISALIGN_TRAP_EN
  logic trap, trap_next;
  logic redirect_bad;
  assign redirect_tgt = redirect_pc;
  assign redirect_bad = |redirect_pc[1:0];
`else
  assign redirect_tgt = redirect_pc & ~(PC_STEP - 32'd1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_REQ;
    else        state <= state_next;
  end

  // A redirect that arrives while a request is not yet accepted is parked in
  // pend_pc, because the address on the bus must not change until accepted.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_next    = pend;
    pend_pc_next = pend_pc;
    load_instr   = 1'b0;
    drop_valid   = redirect_valid;
    flush_state  = ST_REQ;
`ifdef MISALIGN_TRAP_EN
    trap_next = trap;
    if (redirect_valid) trap_next = redirect_bad;
    if (trap_next) flush_state = ST_FAULT;
`endif
    case (state)
      ST_REQ: begin
        if (redirect_valid) begin
          if (mem_req_ready) begin
            pc_next    = redirect_tgt;
            pend_next  = 1'b0;
            state_next = ST_DRAIN;
          end else begin
            pend_pc_next = redirect_tgt;
            pend_next    = 1'b1;
          end
        end else if (mem_req_ready) begin
          if (pend) begin
            pc_next    = pend_pc;
            pend_next  = 1'b0;
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_next    = redirect_tgt;
          state_next = mem_rsp_valid ? flush_state : ST_DRAIN;
        end else if (mem_rsp_valid) begin
          load_instr = 1'b1;
          pc_next    = next_seq_pc(pc);
          state_next = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (redirect_valid) begin
          pc_next    = redirect_tgt;
          state_next = flush_state;
        end else if (!stall) begin
          drop_valid = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) pc_next = redirect_tgt;
        if (mem_rsp_valid) state_next = flush_state;
      end
`ifdef MISALIGN_TRAP_EN
      ST_FAULT: begin
        if (redirect_valid && !redirect_bad) begin
          pc_next    = redirect_tgt;
          state_next = ST_REQ;
        end
      end
`endif
      default: state_next = ST_REQ;
    endcase
  end

  always_comb begin
    mem_req_valid = rst_n && (state == ST_REQ);
    mem_req_addr  = pc;
`ifdef MISALIGN_TRAP_EN
    fetch_fault   = (state == ST_FAULT);
`else
    fetch_fault   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pend_pc     <= RESET_PC;
      pend        <= 1'b0;
      instruction <= NOP_INSTR;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
      pend    <= pend_next;
      if (load_instr) begin
        instruction <= mem_rsp_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (drop_valid) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap <= 1'b0;
    else        trap <= trap_next;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; a second instance with
// RESET_PC=32'hFFFF_FFFC covers PC wrap-around.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_ready, mem_rsp_valid, redirect_valid, stall;
  logic [31:0] mem_rsp_data, redirect_pc;
  logic        mem_req_valid, instr_valid, fetch_fault;
  logic [31:0] mem_req_addr, instruction, instr_pc;
  logic        w_req_valid, w_instr_valid, w_fault;
  logic [31:0] w_req_addr, w_instruction, w_instr_pc;
  logic        auto_rsp;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(w_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(w_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .instruction(w_instruction), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
    .fetch_fault(w_fault)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'h0050_0093 + a;
  endfunction

  // One clock: the memory model answers an accepted request one cycle later.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    @(posedge clk);
    #1;
    mem_rsp_valid = acc && auto_rsp;
    mem_rsp_data  = data_of(a);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0; auto_rsp = 1'b1;
    #23;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid got %b want 0", mem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_instr_valid got %b want 0", instr_valid); end
    checks++; if (instruction !== 32'h0000_0013) begin errors++; $display("[TB] FAIL rst_instruction got %h want 00000013", instruction); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr_pc got %h want 0", instr_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault got %b want 0", fetch_fault); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_req got %b/%h want 1/00000000", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== a || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_req%0d got %b/%h/%b want 1/%h/0", i, mem_req_valid, mem_req_addr, instr_valid, a); end
      tick();
      checks++; if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_wait%0d got req %b valid %b want 0/0", i, mem_req_valid, instr_valid); end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== a || instruction !== data_of(a)) begin errors++; $display("[TB] FAIL seq_deliver%0d got %b/%h/%h want 1/%h/%h", i, instr_valid, instr_pc, instruction, a, data_of(a)); end
      tick();
    end
  endtask

  task automatic test_stall();
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instruction !== data_of(32'hC) || mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall%0d got %b/%h/%h req %b want 1/0000000c/%h req 0", i, instr_valid, instr_pc, instruction, mem_req_valid, data_of(32'hC)); end
    end
    stall = 1'b0;
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h10 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got %b/%h/%b want 1/00000010/0", mem_req_valid, mem_req_addr, instr_valid); end
  endtask

  task automatic test_redirect_wait();
    auto_rsp = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain got req %b valid %b want 0/0", mem_req_valid, instr_valid); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_req got %b/%h/%b want 1/00000100/0", mem_req_valid, mem_req_addr, instr_valid); end
    auto_rsp = 1'b1;
    tick(); tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instruction !== data_of(32'h100)) begin errors++; $display("[TB] FAIL redir_deliver got %b/%h/%h want 1/00000100/%h", instr_valid, instr_pc, instruction, data_of(32'h100)); end
    tick();
    checks++; if (mem_req_addr !== 32'h104) begin errors++; $display("[TB] FAIL redir_next got %h want 00000104", mem_req_addr); end
  endtask

  task automatic test_redirect_deliver();
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h180;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h180 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL squash got %b/%h/%b want 1/00000180/0", mem_req_valid, mem_req_addr, instr_valid); end
  endtask

  task automatic test_ready_low_redirect();
    mem_req_ready = 1'b0;
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h180) begin errors++; $display("[TB] FAIL hold0 got %b/%h want 1/00000180", mem_req_valid, mem_req_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h180) begin errors++; $display("[TB] FAIL hold%0d got %b/%h want 1/00000180", i, mem_req_valid, mem_req_addr); end
      if (i < 3) tick();
    end
    mem_req_ready = 1'b1;
    tick();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_drain got %b want 0", mem_req_valid); end
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_target got %b/%h/%b want 1/00000200/0", mem_req_valid, mem_req_addr, instr_valid); end
    tick(); tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instruction !== data_of(32'h200)) begin errors++; $display("[TB] FAIL hold_deliver got %b/%h/%h want 1/00000200/%h", instr_valid, instr_pc, instruction, data_of(32'h200)); end
    tick();
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; mem_rsp_valid = 1'b0;
    #2;
    checks++; if (instr_valid !== 1'b0 || mem_req_valid !== 1'b0 || w_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset got %b/%b/%b want 0/0/0", instr_valid, mem_req_valid, w_req_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_first got %b/%h want 1/fffffffc", w_req_valid, w_req_addr); end
    tick(); tick();
    checks++; if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_deliver got %b/%h want 1/fffffffc", w_instr_valid, w_instr_pc); end
    tick();
    checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_second got %b/%h want 1/00000000", w_req_valid, w_req_addr); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b0 || fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL mis_drain got req %b fault %b want 0/0", mem_req_valid, fetch_fault); end
    tick();
`ifdef MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_fault !== 1'b1 || mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL fault%0d got fault %b req %b valid %b want 1/0/0", i, fetch_fault, mem_req_valid, instr_valid); end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h104;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h104) begin errors++; $display("[TB] FAIL fault_clear got %b/%b/%h want 0/1/00000104", fetch_fault, mem_req_valid, mem_req_addr); end
`else
    checks++; if (fetch_fault !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL mis_ignored got %b/%b/%h want 0/1/00000100", fetch_fault, mem_req_valid, mem_req_addr); end
    tick();
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL mis_fault_tied got %b want 0", fetch_fault); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_deliver();
    test_ready_low_redirect();
    test_wrap();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Runaway guard in case the bench loses track of the clock.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
